// File: rtl/midi_event_parser_if.sv
// midi_event_parser_if
//   Groups the byte input strobe, the event FIFO handshake and the status
//   outputs of midi_event_parser into one bundle.
//   slave  modport : the parser's view (bytes in, events and status out)
//   master modport : the producer/consumer view (bytes out, events in)
//   Signals:
//     byte_valid  one-cycle strobe marking a received MIDI byte
//     byte_data   the received MIDI byte
//     ev_valid    event FIFO non-empty
//     ev_ready    consumer accepts the head event
//     ev_note_on  1 = note-on, 0 = note-off
//     ev_note     note number (bit 7 always 0)
//     ev_velocity velocity (0 for note-off)
//     modulation  last CC#1 value seen on the configured channel
//     overflow    sticky: an event was dropped because the FIFO was full
interface midi_event_parser_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [7:0] ev_note;
  logic [6:0] ev_velocity;
  logic [6:0] modulation;
  logic       overflow;

  modport slave (
    input  byte_valid, byte_data, ev_ready,
    output ev_valid, ev_note_on, ev_note, ev_velocity, modulation, overflow
  );

  modport master (
    output byte_valid, byte_data, ev_ready,
    input  ev_valid, ev_note_on, ev_note, ev_velocity, modulation, overflow
  );
endinterface

// File: rtl/midi_event_parser.sv
// midi_event_parser
//   Parses a MIDI byte stream for one channel, turning note-on/note-off
//   messages into events queued in a small FIFO and tracking the
//   modulation wheel (CC#1). Realtime bytes are transparent, system and
//   foreign-channel messages are skipped.
//   Ports:
//     mclk  the only clock, all logic on its rising edge
//     rst   asynchronous active-high reset
//     bus   midi_event_parser_if.slave (byte input, event FIFO, status)
//   Parameters:
//     CHANNEL     MIDI channel 0..15 accepted for note/CC messages
//     FIFO_DEPTH  event FIFO entries, power of two, at least 2
//   Build option:
//     MIDI_RUNNING_STATUS_EN  when defined, a completed message keeps its
//     status so further data-byte pairs form new messages (running status).
module midi_event_parser #(
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 mclk,
  input  logic                 rst,
  midi_event_parser_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, DISCARD} state_t;
  // Only the three accepted message kinds are ever retained, so a 2-bit
  // kind replaces the full status byte; KIND_NONE means no running status.
  typedef enum logic [1:0] {KIND_NONE, KIND_OFF, KIND_ON, KIND_CC} kind_t;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } event_t;

  state_t      state_reg, state_next;
  kind_t       kind_reg, kind_next;
  logic [6:0]  d1_reg, d1_next;
  logic [6:0]  mod_reg, mod_next;
  logic        overflow_reg;

  logic        push;
  event_t      push_event;

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  event_t           mem [FIFO_DEPTH];
  event_t           head;
  logic             ev_valid, full, pop, wr_en;

  // ---------------------------------------------------------------
  // Parser
  // ---------------------------------------------------------------
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      kind_reg  <= KIND_NONE;
      d1_reg    <= 7'd0;
      mod_reg   <= 7'd0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      d1_reg    <= d1_next;
      mod_reg   <= mod_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    d1_next    = d1_reg;
    mod_next   = mod_reg;
    push       = 1'b0;
    push_event = '0;

    if (bus.byte_valid) begin
      if (bus.byte_data >= 8'hF8) begin
        // Realtime bytes may interleave anywhere; leave everything alone.
      end else if (bus.byte_data[7]) begin
        // Any status byte aborts a partial message. System common
        // (0xF0..0xF7) falls into the "other status" branch.
        if (bus.byte_data[3:0] == CHANNEL && bus.byte_data[7:4] == 4'h8) begin
          kind_next  = KIND_OFF;
          state_next = WAIT_D1;
        end else if (bus.byte_data[3:0] == CHANNEL && bus.byte_data[7:4] == 4'h9) begin
          kind_next  = KIND_ON;
          state_next = WAIT_D1;
        end else if (bus.byte_data[3:0] == CHANNEL && bus.byte_data[7:4] == 4'hB) begin
          kind_next  = KIND_CC;
          state_next = WAIT_D1;
        end else begin
          kind_next  = KIND_NONE;
          state_next = DISCARD;
        end
      end else begin
        unique case (state_reg)
          IDLE: begin
`ifdef MIDI_RUNNING_STATUS_EN
            if (kind_reg != KIND_NONE) begin
              d1_next    = bus.byte_data[6:0];
              state_next = WAIT_D2;
            end
`endif
          end
          WAIT_D1: begin
            d1_next    = bus.byte_data[6:0];
            state_next = WAIT_D2;
          end
          WAIT_D2: begin
            unique case (kind_reg)
              KIND_ON: begin
                // Note-on with zero velocity is a note-off by convention.
                push            = 1'b1;
                push_event.on   = (bus.byte_data[6:0] != 7'd0);
                push_event.note = d1_reg;
                push_event.vel  = bus.byte_data[6:0];
              end
              KIND_OFF: begin
                push            = 1'b1;
                push_event.on   = 1'b0;
                push_event.note = d1_reg;
                push_event.vel  = 7'd0;
              end
              KIND_CC: begin
                if (d1_reg == 7'd1) mod_next = bus.byte_data[6:0];
              end
              default: ;
            endcase
`ifdef MIDI_RUNNING_STATUS_EN
            state_next = WAIT_D1;
`else
            state_next = IDLE;
`endif
          end
          DISCARD: ;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------
  assign ev_valid = (count_reg != '0);
  assign full     = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = ev_valid && bus.ev_ready;
  // When full, a simultaneous pop frees the slot the write pointer
  // addresses (wr_ptr == rd_ptr), so the push is still accepted.
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
      if (push && !wr_en) overflow_reg <= 1'b1;
    end
  end

  // Storage is not reset; empty-state outputs are forced to zero below.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      always_ff @(posedge mclk) begin
        if (wr_en && wr_ptr_reg == PTR_W'(gi)) mem[gi] <= push_event;
      end
    end
  endgenerate

  // The head is read combinationally so an event is visible the cycle
  // right after it is pushed.
  assign head = mem[rd_ptr_reg];

  assign bus.ev_valid    = ev_valid;
  assign bus.ev_note_on  = ev_valid & head.on;
  assign bus.ev_note     = {1'b0, ev_valid ? head.note : 7'd0};
  assign bus.ev_velocity = ev_valid ? head.vel : 7'd0;
  assign bus.modulation  = mod_reg;
  assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_midi_event_parser.sv
module tb_midi_event_parser;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  midi_event_parser_if bus ();

  midi_event_parser #(
    .CHANNEL   (4'd0),
    .FIFO_DEPTH(4)
  ) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 mclk = ~mclk;

  // Drive one byte for one cycle; returns 1 time unit after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge mclk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic pop_one();
    bus.ev_ready = 1'b1;
    @(posedge mclk);
    #1;
    bus.ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid got %h want 0", bus.ev_valid); end
    n_cmp++; if (bus.ev_note_on !== 1'b0) begin n_fail++; $display("FAIL reset_note_on got %h want 0", bus.ev_note_on); end
    n_cmp++; if (bus.ev_note !== 8'h00) begin n_fail++; $display("FAIL reset_note got %h want 00", bus.ev_note); end
    n_cmp++; if (bus.ev_velocity !== 7'h00) begin n_fail++; $display("FAIL reset_velocity got %h want 00", bus.ev_velocity); end
    n_cmp++; if (bus.modulation !== 7'h00) begin n_fail++; $display("FAIL reset_modulation got %h want 00", bus.modulation); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %h want 0", bus.overflow); end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_note_on();
    send_byte(8'h90);
    send_byte(8'h3C);
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL note_on_early_valid got %h want 0", bus.ev_valid); end
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b1) begin n_fail++; $display("FAIL note_on_valid got %h want 1", bus.ev_valid); end
    n_cmp++; if (bus.ev_note_on !== 1'b1) begin n_fail++; $display("FAIL note_on_on got %h want 1", bus.ev_note_on); end
    n_cmp++; if (bus.ev_note !== 8'h3C) begin n_fail++; $display("FAIL note_on_note got %h want 3c", bus.ev_note); end
    n_cmp++; if (bus.ev_velocity !== 7'h64) begin n_fail++; $display("FAIL note_on_vel got %h want 64", bus.ev_velocity); end
    // Held stable while not ready.
    @(posedge mclk); #1;
    n_cmp++; if (bus.ev_note !== 8'h3C || bus.ev_valid !== 1'b1) begin n_fail++; $display("FAIL note_on_hold got %h/%h want 3c/1", bus.ev_note, bus.ev_valid); end
    pop_one();
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL note_on_popped got %h want 0", bus.ev_valid); end
    $display("test_note_on: 90 3c 64 -> note-on 3c/64");
  endtask

  task automatic test_running_status();
    send_byte(8'h90);
    send_byte(8'h40);
    send_byte(8'h50);
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note_on !== 1'b1 || bus.ev_note !== 8'h40 || bus.ev_velocity !== 7'h50) begin
      n_fail++; $display("FAIL rs_first got v=%h on=%h n=%h vel=%h want 1/1/40/50", bus.ev_valid, bus.ev_note_on, bus.ev_note, bus.ev_velocity); end
    pop_one();
    send_byte(8'h40);
    send_byte(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note_on !== 1'b0 || bus.ev_note !== 8'h40 || bus.ev_velocity !== 7'h00) begin
      n_fail++; $display("FAIL rs_second got v=%h on=%h n=%h vel=%h want 1/0/40/00", bus.ev_valid, bus.ev_note_on, bus.ev_note, bus.ev_velocity); end
    pop_one();
`else
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL rs_dropped got %h want 0", bus.ev_valid); end
`endif
    // Explicit note-off status, any velocity -> vel 0.
    send_byte(8'h80);
    send_byte(8'h22);
    send_byte(8'h33);
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note_on !== 1'b0 || bus.ev_note !== 8'h22 || bus.ev_velocity !== 7'h00) begin
      n_fail++; $display("FAIL note_off got v=%h on=%h n=%h vel=%h want 1/0/22/00", bus.ev_valid, bus.ev_note_on, bus.ev_note, bus.ev_velocity); end
    pop_one();
    $display("test_running_status: second pair and 0x80 note-off checked");
  endtask

  task automatic test_channel_filter();
    send_byte(8'h91);
    send_byte(8'h3C);
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL other_channel got %h want 0", bus.ev_valid); end
    send_byte(8'hB0);
    send_byte(8'h01);
    send_byte(8'h7F);
    n_cmp++; if (bus.modulation !== 7'h7F) begin n_fail++; $display("FAIL cc1_mod got %h want 7f", bus.modulation); end
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL cc1_no_event got %h want 0", bus.ev_valid); end
    send_byte(8'hB0);
    send_byte(8'h07);
    send_byte(8'h22);
    n_cmp++; if (bus.modulation !== 7'h7F) begin n_fail++; $display("FAIL cc7_ignored got %h want 7f", bus.modulation); end
    // Sysex start then data: discarded.
    send_byte(8'hF0);
    send_byte(8'h3C);
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL sysex_discard got %h want 0", bus.ev_valid); end
    $display("test_channel_filter: foreign channel, CC1, CC7, sysex checked");
  endtask

  task automatic test_realtime();
    send_byte(8'h90);
    send_byte(8'hF8);
    send_byte(8'h3C);
    send_byte(8'hFE);
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL rt_early got %h want 0", bus.ev_valid); end
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note_on !== 1'b1 || bus.ev_note !== 8'h3C || bus.ev_velocity !== 7'h64) begin
      n_fail++; $display("FAIL rt_event got v=%h on=%h n=%h vel=%h want 1/1/3c/64", bus.ev_valid, bus.ev_note_on, bus.ev_note, bus.ev_velocity); end
    pop_one();
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL rt_single got %h want 0", bus.ev_valid); end
    $display("test_realtime: interleaved F8/FE transparent");
  endtask

  task automatic test_full_push_pop();
    logic [7:0] n, v;
    for (int i = 0; i < 4; i++) begin
      n = 8'h30 + 8'(i); v = 8'h10 + 8'(i);
      send_byte(8'h90); send_byte(n); send_byte(v);
    end
    send_byte(8'h90);
    send_byte(8'h34);
    bus.ev_ready = 1'b1;
    send_byte(8'h14);
    bus.ev_ready = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_ovf got %h want 0", bus.overflow); end
    for (int i = 1; i < 5; i++) begin
      n = 8'h30 + 8'(i); v = 8'h10 + 8'(i);
      n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note !== n || bus.ev_velocity !== v[6:0]) begin
        n_fail++; $display("FAIL full_drain_%0d got v=%h n=%h vel=%h want 1/%h/%h", i, bus.ev_valid, bus.ev_note, bus.ev_velocity, n, v[6:0]); end
      pop_one();
    end
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got %h want 0", bus.ev_valid); end
    $display("test_full_push_pop: push+pop while full accepted");
  endtask

  task automatic test_overflow();
    logic [7:0] n, v;
    for (int i = 0; i < 5; i++) begin
      n = 8'h40 + 8'(i); v = 8'h20 + 8'(i);
      send_byte(8'h90); send_byte(n); send_byte(v);
      if (i == 3) begin
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_four got %h want 0", bus.overflow); end
      end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %h want 1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      n = 8'h40 + 8'(i); v = 8'h20 + 8'(i);
      n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note !== n || bus.ev_velocity !== v[6:0]) begin
        n_fail++; $display("FAIL ovf_drain_%0d got v=%h n=%h vel=%h want 1/%h/%h", i, bus.ev_valid, bus.ev_note, bus.ev_velocity, n, v[6:0]); end
      pop_one();
    end
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth_absent got %h want 0", bus.ev_valid); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %h want 1", bus.overflow); end
    $display("test_overflow: four held, fifth dropped, overflow sticky");
  endtask

  task automatic test_reset_midmsg();
    send_byte(8'h90);
    send_byte(8'h3C);
    #2 rst = 1'b1;
    #1;
    test_reset();
    #2 rst = 1'b0;
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL midmsg_lost got %h want 0", bus.ev_valid); end
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'h64);
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_note_on !== 1'b1 || bus.ev_note !== 8'h3C || bus.ev_velocity !== 7'h64) begin
      n_fail++; $display("FAIL midmsg_after got v=%h on=%h n=%h vel=%h want 1/1/3c/64", bus.ev_valid, bus.ev_note_on, bus.ev_note, bus.ev_velocity); end
    pop_one();
    $display("test_reset_midmsg: partial message lost across reset");
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.ev_ready   = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge mclk); #1;
    test_note_on();
    test_running_status();
    test_channel_filter();
    test_realtime();
    test_full_push_pop();
    test_overflow();
    test_reset_midmsg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_event_parser.md
MIDI_EVENT_PARSER -- requirements
Module: midi_event_parser

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'd0, the MIDI channel (0..15) accepted for note/CC messages.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of event-FIFO entries (power of 2, at least 2).
REQ-003 mclk  input  1  the only clock; all logic on posedge mclk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 byte_valid  input  1  one-cycle strobe; byte_data is valid in that cycle.
REQ-006 byte_data  input  8  received MIDI byte from the UART receiver.
REQ-007 ev_valid  output  1  event FIFO is non-empty.
REQ-008 ev_ready  input  1  consumer (voice distributor) accepts the head event.
REQ-009 ev_note_on  output  1  1 = note-on, 0 = note-off.
REQ-010 ev_note  output  8  note number, bit 7 always 0.
REQ-011 ev_velocity  output  7  velocity; always 0 for note-off.
REQ-012 modulation  output  7  last CC#1 value on CHANNEL.
REQ-013 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-014 Parser SHALL have states IDLE, WAIT_D1, WAIT_D2 and DISCARD.
REQ-015 A byte 0xF8..0xFF (realtime) SHALL be ignored with no change to state, stored data or running status.
REQ-016 A byte 0xF0..0xF7 SHALL clear running status and go to DISCARD.
REQ-017 Status 0x8n, 0x9n or 0xBn with n==CHANNEL SHALL store the status and go to WAIT_D1; any other status SHALL clear running status and go to DISCARD.
REQ-018 A data byte (bit7=0) in WAIT_D1 SHALL store d1 and go to WAIT_D2.
REQ-019 A data byte in WAIT_D2 SHALL complete the message; 0x9n with d2>0 SHALL push {on=1, note=d1, vel=d2}.
REQ-020 On completion, 0x8n (any d2) or 0x9n with d2=0 SHALL push {on=0, note=d1, vel=0}.
REQ-021 On completion, 0xBn with d1==1 SHALL set modulation<=d2 and push no event; other CC numbers SHALL be ignored.
REQ-022 A data byte in DISCARD SHALL be dropped and the state SHALL stay DISCARD.
REQ-023 A new status byte SHALL abort any partial message with no event.
REQ-024 A pushed event SHALL appear at the FIFO output with ev_valid=1 in the cycle after the byte_valid cycle of its final data byte.
REQ-025 FIFO SHALL be first-in first-out; pop occurs when ev_valid&&ev_ready; outputs SHALL show the head entry and SHALL be held stable while ev_valid&&!ev_ready.
REQ-026 A push while the FIFO is full with no pop SHALL drop the new event and set overflow=1; only rst clears overflow.
REQ-027 A push and pop in the same cycle while full SHALL accept the push without setting overflow.
REQ-028 Push and pop in the same cycle while empty SHALL NOT occur because ev_valid=0; the pushed event SHALL be presented next cycle.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, clear running status and stored d1, empty the FIFO, and drive ev_valid=0, ev_note_on=0, ev_note=0, ev_velocity=0, modulation=0 and overflow=0.
REQ-030 A message in progress at reset SHALL be lost; later data bytes SHALL be treated as data in IDLE.

Configuration
REQ-031 With MIDI_RUNNING_STATUS_EN defined, completion SHALL return to WAIT_D1 with status retained, and a data byte in IDLE SHALL be treated as d1 when a valid status is retained.
REQ-032 Without MIDI_RUNNING_STATUS_EN, completion SHALL go to IDLE, and a data byte in IDLE SHALL be dropped.

Verification
REQ-033 0x90,0x3C,0x64 -> one event {on=1, note=0x3C, vel=0x64}, ev_valid high 1 cycle after the last byte.
REQ-034 0x90,0x40,0x50,0x40,0x00 -> with macro: note-on 0x40 then note-off 0x40 (vel 0); without macro: only the note-on.
REQ-035 CHANNEL=0: 0x91,0x3C,0x64 -> no event; 0xB0,0x01,0x7F -> modulation=0x7F, no event.
REQ-036 0x90,0xF8,0x3C,0xFE,0x64 -> single event identical to REQ-033.
REQ-037 ev_ready=0, five distinct note-ons -> four held and overflow=1; then ev_ready=1 drains the four in order, and the fifth is absent.
REQ-038 0x90,0x3C, rst pulse, 0x64 -> no event, all outputs 0; then 0x90,0x3C,0x64 -> normal event.
